// File: rtl/instr_encoder.sv
// Instruction encoder: packs instruction fields into 16-bit words, range-checks the
// immediate, and streams accepted words to instruction memory through a 4-deep FIFO.
module instr_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] start_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [2:0]  in_rs,
   input  logic [2:0]  in_rt,
   input  logic [2:0]  in_rd,
   input  logic [1:0]  in_func,
   input  logic [15:0] in_imm,
   output logic        mem_wr_en,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wr_data,
   input  logic        mem_ready,
   output logic        done,
   output logic        err,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

   stateT       state;
   logic [15:0] fifoMem [4];
   logic [1:0]  wrPtr;
   logic [1:0]  rdPtr;
   logic [2:0]  count;
   logic [15:0] encWord;
   logic        immOk;
   logic        accept;
   logic        push;
   logic        pop;
   logic        sFit5;
   logic        sFit8;
   logic        sFit11;
   logic        uFit5;
   logic        uFit8;

   // A value fits n signed bits when bits [15:n-1] are all copies of the sign.
   assign sFit5  = (&in_imm[15:4])  | ~(|in_imm[15:4]);
   assign sFit8  = (&in_imm[15:7])  | ~(|in_imm[15:7]);
   assign sFit11 = (&in_imm[15:10]) | ~(|in_imm[15:10]);
   assign uFit5  = ~(|in_imm[15:5]);
   assign uFit8  = ~(|in_imm[15:8]);

   assign in_ready    = (state == RUN) && (count != 3'd4);
   assign accept      = in_valid & in_ready;
   assign push        = accept & immOk;
   assign mem_wr_en   = (count != 3'd0);
   assign pop         = mem_wr_en & mem_ready;
   assign mem_wr_data = mem_wr_en ? fifoMem[rdPtr] : 16'h0000;

   always_comb begin
      encWord = {in_op, 11'd0};
      immOk   = 1'b1;
      case (in_op)
         5'b00100, 5'b00110: begin
            encWord[10:0] = in_imm[10:0];
            immOk         = sFit11;
         end
         5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
            encWord[10:0] = {in_rs, in_rd, in_imm[4:0]};
            immOk         = sFit5;
         end
         5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
            encWord[10:0] = {in_rs, in_rd, in_imm[4:0]};
            immOk         = uFit5;
         end
         5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111: begin
            encWord[10:0] = {in_rs, in_imm[7:0]};
            immOk         = sFit8;
         end
         5'b10010: begin
            encWord[10:0] = {in_rs, in_imm[7:0]};
            immOk         = uFit8;
         end
         5'b11010, 5'b11011: begin
            encWord[10:0] = {in_rs, in_rt, in_rd, in_func};
         end
         // BTR and the set-condition ops carry no function code.
         5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
            encWord[10:0] = {in_rs, in_rt, in_rd, 2'b00};
         end
         default: begin
            encWord[10:0] = 11'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr] <= encWord;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wrPtr    <= 2'd0;
         rdPtr    <= 2'd0;
         count    <= 3'd0;
         mem_addr <= 16'h0000;
         done     <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= 8'd0;
      end else begin
         err <= accept & ~immOk;
         if (accept && !immOk && err_cnt != 8'd255) begin
            err_cnt <= err_cnt + 8'd1;
         end
         if (push) begin
            wrPtr <= wrPtr + 2'd1;
         end
         if (pop) begin
            rdPtr    <= rdPtr + 2'd1;
            mem_addr <= mem_addr + 16'd2;
         end
         count <= count + {2'b00, push} - {2'b00, pop};
         // A start load of the address takes precedence; the FIFO is empty then anyway.
         case (state)
            IDLE: begin
               if (start) begin
                  mem_addr <= start_addr;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (accept && in_op == 5'b00000) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (count == 3'd0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (start) begin
                  mem_addr <= start_addr;
                  done     <= 1'b0;
                  state    <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
